// File: rtl/idex_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// idex_hazard_stage_if
// Bundle between the decode stage and the ID/EX hazard register.
//   master : decode side; drives the decoded id_* bundle and the downstream
//            flush, and observes the EX slot, stall controls and stall counter.
//   slave  : the ID/EX stage itself.
// Signals:
//   id_*        decoded instruction presented in the IF/ID slot
//   flush       taken branch/jump resolved downstream, kill the ID/EX slot
//   ex_*        registered EX-stage slot
//   pc_write    PC update enable
//   ifid_write  IF/ID register update enable
//   stall_count saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
interface idex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic              id_MemRead, id_MemWrite, id_Branch, id_Jump;
  logic [3:0]        id_ALUOperation;
  logic              id_uses_rs, id_uses_rt;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc;
  logic              flush;

  logic              ex_valid;
  logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
  logic              ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
  logic [3:0]        ex_ALUOperation;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
  logic              pc_write, ifid_write;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOperation,
           id_uses_rs, id_uses_rt, id_rs, id_rt, id_rd,
           id_rdata1, id_rdata2, id_imm, id_pc, flush,
    input  ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOperation,
           ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc,
           pc_write, ifid_write, stall_count
  );

  modport slave (
    input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOperation,
           id_uses_rs, id_uses_rt, id_rs, id_rt, id_rd,
           id_rdata1, id_rdata2, id_imm, id_pc, flush,
    output ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOperation,
           ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc,
           pc_write, ifid_write, stall_count
  );
endinterface

// File: rtl/idex_hazard_stage.sv
// ---------------------------------------------------------------------------
// idex_hazard_stage
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// PC / IF-ID stall control, flush handling and a saturating stall counter.
// Ports:
//   clk    system clock (all state on the rising edge)
//   rst_n  synchronous active-low reset
//   bus    idex_hazard_stage_if.slave: id_* bundle and flush in,
//          ex_* slot, pc_write, ifid_write and stall_count out
// Parameters:
//   DATA_W  operand / immediate / PC width
//   REG_AW  register-index width
//   R0_ZERO when nonzero, register 0 never creates a hazard
//   CNT_W   stall counter width
// ---------------------------------------------------------------------------
module idex_hazard_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  idex_hazard_stage_if.slave   bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [3:0]        alu_op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } ex_slot_t;

  ex_slot_t         ex_q;
  ex_slot_t         ex_d;
  ex_slot_t         id_slot;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic             rs_match;
  logic             rt_match;
  logic             r0_load;
  logic             hazard;

  // Control bits of an invalid IF/ID slot are forced to zero so a dead slot
  // can never write the register file or memory further down the pipe.
  always_comb begin
    id_slot            = '0;
    id_slot.valid      = bus.id_valid;
    id_slot.reg_dst    = bus.id_valid & bus.id_RegDst;
    id_slot.alu_src    = bus.id_valid & bus.id_ALUSrc;
    id_slot.mem_to_reg = bus.id_valid & bus.id_MemtoReg;
    id_slot.reg_write  = bus.id_valid & bus.id_RegWrite;
    id_slot.mem_read   = bus.id_valid & bus.id_MemRead;
    id_slot.mem_write  = bus.id_valid & bus.id_MemWrite;
    id_slot.branch     = bus.id_valid & bus.id_Branch;
    id_slot.jump       = bus.id_valid & bus.id_Jump;
    id_slot.alu_op     = bus.id_valid ? bus.id_ALUOperation : 4'b0000;
    id_slot.rs         = bus.id_rs;
    id_slot.rt         = bus.id_rt;
    id_slot.rd         = bus.id_rd;
    id_slot.rdata1     = bus.id_rdata1;
    id_slot.rdata2     = bus.id_rdata2;
    id_slot.imm        = bus.id_imm;
    id_slot.pc         = bus.id_pc;
  end

  // A load always targets rt. Only operands the instruction really reads
  // count, and a load into r0 is harmless when r0 is hard-wired to zero.
  always_comb begin
    rs_match = bus.id_uses_rs && (bus.id_rs == ex_q.rt);
    rt_match = bus.id_uses_rt && (bus.id_rt == ex_q.rt);
    r0_load  = (R0_ZERO != 0) && (ex_q.rt == '0);
    hazard   = ex_q.valid && ex_q.mem_read && bus.id_valid &&
               (rs_match || rt_match) && !r0_load;
  end

  // A flush releases the stall so fetch can redirect immediately.
  assign bus.pc_write   = !hazard || bus.flush;
  assign bus.ifid_write = !hazard || bus.flush;

  // Flush beats hazard: a flushed cycle is not counted as a stall. The
  // bubble clears ex_MemRead, so a hazard never lasts beyond one cycle.
  always_comb begin
    ex_d    = '0;
    stall_d = stall_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (hazard) begin
      ex_d = '0;
      if (stall_q != '1) begin
        stall_d = stall_q + CNT_W'(1);
      end
    end else begin
      ex_d = id_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      stall_q <= stall_d;
    end
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_RegDst       = ex_q.reg_dst;
  assign bus.ex_ALUSrc       = ex_q.alu_src;
  assign bus.ex_MemtoReg     = ex_q.mem_to_reg;
  assign bus.ex_RegWrite     = ex_q.reg_write;
  assign bus.ex_MemRead      = ex_q.mem_read;
  assign bus.ex_MemWrite     = ex_q.mem_write;
  assign bus.ex_Branch       = ex_q.branch;
  assign bus.ex_Jump         = ex_q.jump;
  assign bus.ex_ALUOperation = ex_q.alu_op;
  assign bus.ex_rs           = ex_q.rs;
  assign bus.ex_rt           = ex_q.rt;
  assign bus.ex_rd           = ex_q.rd;
  assign bus.ex_rdata1       = ex_q.rdata1;
  assign bus.ex_rdata2       = ex_q.rdata2;
  assign bus.ex_imm          = ex_q.imm;
  assign bus.ex_pc           = ex_q.pc;
  assign bus.stall_count     = stall_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_idex_hazard_stage
// Directed bench for idex_hazard_stage. A main instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=2) receive identical stimulus. Control bits
// are packed as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump}.
// ---------------------------------------------------------------------------
module tb_idex_hazard_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [7:0] C_ADD = 8'h90;  // RegDst, RegWrite
  localparam logic [7:0] C_LW  = 8'h78;  // ALUSrc, MemtoReg, RegWrite, MemRead

  logic clk;
  logic rst_n;

  idex_hazard_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(16)) bus_main ();
  idex_hazard_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(2))  bus_sat ();

  idex_hazard_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .R0_ZERO(1), .CNT_W(16)) dut_main (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_main)
  );

  idex_hazard_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .R0_ZERO(1), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [7:0]  ctrl;
    logic [3:0]  alu;
    logic        uses_rs;
    logic        uses_rt;
    logic [3:0]  rs, rt, rd;
    logic [31:0] d;
    logic        exp_pcw;
    logic        exp_valid;
    logic [7:0]  exp_ctrl;
    logic [3:0]  exp_alu;
    logic [3:0]  exp_rs, exp_rt, exp_rd;
    logic [31:0] exp_d;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[20];
  int   checks = 0;
  int   passes = 0;

  // Operand pattern {rdata1, rdata2, imm, pc} derived from one seed; seed 0
  // stands for the all-zero bubble.
  function automatic logic [127:0] dataOf(input logic [31:0] d);
    if (d == 32'h0) return '0;
    return {d, d + 32'd1, d + 32'd2, d + 32'd3};
  endfunction

  function automatic vec_t mk(
    input string n, input logic r, input logic f, input logic v,
    input logic [7:0] c, input logic [3:0] a, input logic urs, input logic urt,
    input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd, input logic [31:0] d,
    input logic epcw, input logic ev, input logic [7:0] ec, input logic [3:0] ea,
    input logic [3:0] ers, input logic [3:0] ert, input logic [3:0] erd,
    input logic [31:0] ed, input logic [15:0] ecnt);
    vec_t t;
    t.name = n; t.rst_n = r; t.flush = f; t.valid = v; t.ctrl = c; t.alu = a;
    t.uses_rs = urs; t.uses_rt = urt; t.rs = rs; t.rt = rt; t.rd = rd; t.d = d;
    t.exp_pcw = epcw; t.exp_valid = ev; t.exp_ctrl = ec; t.exp_alu = ea;
    t.exp_rs = ers; t.exp_rt = ert; t.exp_rd = erd; t.exp_d = ed; t.exp_cnt = ecnt;
    return t;
  endfunction

  task automatic applyStimulus(
    input logic r, input logic f, input logic v, input logic [7:0] c, input logic [3:0] a,
    input logic urs, input logic urt, input logic [3:0] rs, input logic [3:0] rt,
    input logic [3:0] rd, input logic [31:0] d);
    logic [127:0] p;
    p = dataOf(d);
    rst_n = r;
    {bus_main.id_RegDst, bus_main.id_ALUSrc, bus_main.id_MemtoReg, bus_main.id_RegWrite,
     bus_main.id_MemRead, bus_main.id_MemWrite, bus_main.id_Branch, bus_main.id_Jump} = c;
    {bus_sat.id_RegDst, bus_sat.id_ALUSrc, bus_sat.id_MemtoReg, bus_sat.id_RegWrite,
     bus_sat.id_MemRead, bus_sat.id_MemWrite, bus_sat.id_Branch, bus_sat.id_Jump} = c;
    bus_main.flush = f;            bus_sat.flush = f;
    bus_main.id_valid = v;         bus_sat.id_valid = v;
    bus_main.id_ALUOperation = a;  bus_sat.id_ALUOperation = a;
    bus_main.id_uses_rs = urs;     bus_sat.id_uses_rs = urs;
    bus_main.id_uses_rt = urt;     bus_sat.id_uses_rt = urt;
    bus_main.id_rs = rs;           bus_sat.id_rs = rs;
    bus_main.id_rt = rt;           bus_sat.id_rt = rt;
    bus_main.id_rd = rd;           bus_sat.id_rd = rd;
    {bus_main.id_rdata1, bus_main.id_rdata2, bus_main.id_imm, bus_main.id_pc} = p;
    {bus_sat.id_rdata1, bus_sat.id_rdata2, bus_sat.id_imm, bus_sat.id_pc} = p;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end else begin
      passes++;
    end
  endtask

  task automatic checkStall(input string name, input logic exp_pcw);
    checkOutput({name, ".pc_write"}, 128'(bus_main.pc_write), 128'(exp_pcw));
    checkOutput({name, ".ifid_write"}, 128'(bus_main.ifid_write), 128'(exp_pcw));
  endtask

  task automatic checkEx(input string name, input logic ev, input logic [7:0] ec,
                         input logic [3:0] ea, input logic [3:0] ers, input logic [3:0] ert,
                         input logic [3:0] erd, input logic [31:0] ed, input logic [15:0] ecnt);
    checkOutput({name, ".ex_valid"}, 128'(bus_main.ex_valid), 128'(ev));
    checkOutput({name, ".ex_ctrl"},
                128'({bus_main.ex_RegDst, bus_main.ex_ALUSrc, bus_main.ex_MemtoReg,
                      bus_main.ex_RegWrite, bus_main.ex_MemRead, bus_main.ex_MemWrite,
                      bus_main.ex_Branch, bus_main.ex_Jump}), 128'(ec));
    checkOutput({name, ".ex_alu"}, 128'(bus_main.ex_ALUOperation), 128'(ea));
    checkOutput({name, ".ex_fields"},
                128'({bus_main.ex_rs, bus_main.ex_rt, bus_main.ex_rd}), 128'({ers, ert, erd}));
    checkOutput({name, ".ex_data"},
                {bus_main.ex_rdata1, bus_main.ex_rdata2, bus_main.ex_imm, bus_main.ex_pc},
                dataOf(ed));
    checkOutput({name, ".stall_count"}, 128'(bus_main.stall_count), 128'(ecnt));
  endtask

  initial begin
    vecs[0]  = mk("add_pass",     1,0,1,C_ADD,4'd1,1,1, 4'd2,4'd3,4'd5, 32'h10,  1, 1,C_ADD,4'd1, 4'd2,4'd3,4'd5, 32'h10, 16'd0);
    vecs[1]  = mk("lw_rt4",       1,0,1,C_LW, 4'd2,1,0, 4'd2,4'd4,4'd0, 32'h20,  1, 1,C_LW, 4'd2, 4'd2,4'd4,4'd0, 32'h20, 16'd0);
    vecs[2]  = mk("loaduse_rs",   1,0,1,C_ADD,4'd1,1,1, 4'd4,4'd7,4'd8, 32'h30,  0, 0,8'h00,4'd0, 4'd0,4'd0,4'd0, 32'h0,  16'd1);
    vecs[3]  = mk("dep_retry",    1,0,1,C_ADD,4'd1,1,1, 4'd4,4'd7,4'd8, 32'h30,  1, 1,C_ADD,4'd1, 4'd4,4'd7,4'd8, 32'h30, 16'd1);
    vecs[4]  = mk("lw_r0",        1,0,1,C_LW, 4'd2,1,0, 4'd1,4'd0,4'd0, 32'h40,  1, 1,C_LW, 4'd2, 4'd1,4'd0,4'd0, 32'h40, 16'd1);
    vecs[5]  = mk("r0_dep",       1,0,1,C_ADD,4'd1,1,1, 4'd0,4'd0,4'd9, 32'h50,  1, 1,C_ADD,4'd1, 4'd0,4'd0,4'd9, 32'h50, 16'd1);
    vecs[6]  = mk("lw_rt6",       1,0,1,C_LW, 4'd2,1,0, 4'd1,4'd6,4'd0, 32'h60,  1, 1,C_LW, 4'd2, 4'd1,4'd6,4'd0, 32'h60, 16'd1);
    vecs[7]  = mk("rt_unused",    1,0,1,C_ADD,4'd1,1,0, 4'd2,4'd6,4'd10,32'h70,  1, 1,C_ADD,4'd1, 4'd2,4'd6,4'd10,32'h70, 16'd1);
    vecs[8]  = mk("invalid_slot", 1,0,0,C_ADD,4'd1,1,1, 4'd13,4'd11,4'd12,32'h80,1, 0,8'h00,4'd0, 4'd13,4'd11,4'd12,32'h80,16'd1);
    vecs[9]  = mk("lw_rt5",       1,0,1,C_LW, 4'd2,1,0, 4'd1,4'd5,4'd0, 32'h90,  1, 1,C_LW, 4'd2, 4'd1,4'd5,4'd0, 32'h90, 16'd1);
    vecs[10] = mk("dep_invalid",  1,0,0,C_ADD,4'd1,1,1, 4'd5,4'd1,4'd2, 32'hA0,  1, 0,8'h00,4'd0, 4'd5,4'd1,4'd2, 32'hA0, 16'd1);
    vecs[11] = mk("lw_rt3",       1,0,1,C_LW, 4'd2,1,0, 4'd1,4'd3,4'd0, 32'hB0,  1, 1,C_LW, 4'd2, 4'd1,4'd3,4'd0, 32'hB0, 16'd1);
    vecs[12] = mk("flush_hazard", 1,1,1,C_ADD,4'd1,0,1, 4'd9,4'd3,4'd4, 32'hC0,  1, 0,8'h00,4'd0, 4'd0,4'd0,4'd0, 32'h0,  16'd1);
    vecs[13] = mk("flush_only",   1,1,1,C_ADD,4'd1,1,1, 4'd2,4'd3,4'd4, 32'hC8,  1, 0,8'h00,4'd0, 4'd0,4'd0,4'd0, 32'h0,  16'd1);
    vecs[14] = mk("lw_rt2",       1,0,1,C_LW, 4'd2,1,0, 4'd1,4'd2,4'd0, 32'hD0,  1, 1,C_LW, 4'd2, 4'd1,4'd2,4'd0, 32'hD0, 16'd1);
    vecs[15] = mk("loaduse_rt",   1,0,1,C_ADD,4'd1,0,1, 4'd0,4'd2,4'd3, 32'hE0,  0, 0,8'h00,4'd0, 4'd0,4'd0,4'd0, 32'h0,  16'd2);
    vecs[16] = mk("dep_retry_rt", 1,0,1,C_ADD,4'd1,0,1, 4'd0,4'd2,4'd3, 32'hE0,  1, 1,C_ADD,4'd1, 4'd0,4'd2,4'd3, 32'hE0, 16'd2);
    vecs[17] = mk("lw_rt4b",      1,0,1,C_LW, 4'd2,1,0, 4'd1,4'd4,4'd0, 32'hF0,  1, 1,C_LW, 4'd2, 4'd1,4'd4,4'd0, 32'hF0, 16'd2);
    vecs[18] = mk("reset_stall",  0,0,1,C_ADD,4'd1,1,1, 4'd4,4'd7,4'd8, 32'h100, 0, 0,8'h00,4'd0, 4'd0,4'd0,4'd0, 32'h0,  16'd0);
    vecs[19] = mk("after_reset",  1,0,1,C_ADD,4'd1,1,1, 4'd4,4'd7,4'd8, 32'h100, 1, 1,C_ADD,4'd1, 4'd4,4'd7,4'd8, 32'h100,16'd0);

    // Reset held two cycles with a live RegWrite instruction in ID.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 4'd1, 1'b1, 1'b1, 4'd1, 4'd1, 4'd1, 32'h55);
    repeat (2) @(posedge clk);
    #1;
    checkEx("reset", 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 16'd0);
    checkOutput("reset.sat_count", 128'(bus_sat.stall_count), 128'd0);
    checkStall("reset", 1'b1);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].valid, vecs[i].ctrl, vecs[i].alu,
                    vecs[i].uses_rs, vecs[i].uses_rt, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                    vecs[i].d);
      #1;
      checkStall(vecs[i].name, vecs[i].exp_pcw);
      @(posedge clk);
      #1;
      checkEx(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_ctrl, vecs[i].exp_alu,
              vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_rd, vecs[i].exp_d, vecs[i].exp_cnt);
      @(negedge clk);
    end

    // Four load-use pairs: the 2-bit counter sticks at 3, the 16-bit one reaches 4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, C_LW, 4'd2, 1'b1, 1'b0, 4'd1, 4'd4, 4'd0, 32'h200);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, C_ADD, 4'd1, 1'b1, 1'b1, 4'd4, 4'd7, 4'd8, 32'h300);
      #1;
      checkStall($sformatf("sat%0d", k), 1'b0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat%0d.main_count", k), 128'(bus_main.stall_count), 128'(k + 1));
      checkOutput($sformatf("sat%0d.sat_count", k), 128'(bus_sat.stall_count),
                  128'((k + 1 > 3) ? 3 : k + 1));
      checkOutput($sformatf("sat%0d.bubble", k), 128'(bus_main.ex_valid), 128'd0);
      @(negedge clk);
      @(negedge clk);
    end
    #1;
    checkOutput("sat_release.ex_rd", 128'(bus_main.ex_rd), 128'd8);
    checkOutput("sat_hold.sat_count", 128'(bus_sat.stall_count), 128'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register placed directly downstream of the opcode control decoder.
- Each cycle it latches the decoder control bundle plus decode-stage operands into the EX stage.
- Detects load-use hazards, inserts bubbles, stalls the PC and IF/ID register, and honours branch flushes from later stages.
- Keeps a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 32, width of register operands, immediate and PC.
- REG_AW, 4, register-index width.
- R0_ZERO, 1, when 1 register index 0 never causes a hazard.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  the IF/ID slot holds a real instruction.
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump  in  1 each  decoder control bits.
- id_ALUOperation  in  4  decoder ALU code.
- id_uses_rs, id_uses_rt  in  1 each  the instruction reads rs or rt.
- id_rs, id_rt, id_rd  in  REG_AW each  register fields.
- id_rdata1, id_rdata2, id_imm, id_pc  in  DATA_W each  operands, sign-extended immediate, PC.
- flush  in  1  branch or jump resolved taken downstream; kill the ID/EX slot.
- ex_valid  out  1  the EX slot holds a real instruction.
- ex_RegDst … ex_Jump, ex_ALUOperation  out  1 each / 4  registered control.
- ex_rs, ex_rt, ex_rd  out  REG_AW each  registered fields.
- ex_rdata1, ex_rdata2, ex_imm, ex_pc  out  DATA_W each  registered data.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID update enable (combinational).
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- All state updates on the rising edge of clk.
- Priority per cycle: reset, then flush, then hazard bubble, then normal capture.

Reset (rst_n=0 at an edge):
- ex_valid and all ex_* control bits/fields/data clear to 0.
- stall_count clears to 0.
- Reset overrides a simultaneous flush or hazard.
- Reset mid-stall leaves no pending stall, because hazard is recomputed from the cleared EX state.

hazard (combinational):
- hazard = ex_valid & ex_MemRead & id_valid & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)) & !(R0_ZERO & ex_rt==0).
- The load destination is always ex_rt.

Outputs pc_write and ifid_write:
- Both equal !hazard | flush.
- Flush releases the stall so fetch redirects.

Flush:
- Next cycle ex_valid=0 and every ex_* output is 0.
- stall_count does not increment, even if hazard was also true.

Hazard without flush (bubble):
- EX receives the all-zero bubble (ex_valid=0, controls 0, data 0).
- IF/ID holds, so the same instruction is re-presented next cycle.
- stall_count increments by 1, saturating at 2^CNT_W-1 with no wrap.
- Hazard clears automatically after one bubble, since ex_MemRead=0.
- Maximum stall per load: 1 cycle.

Normal capture:
- All ex_* outputs take the id_* values; ex_valid=id_valid.
- If id_valid=0, control bits are captured as 0 so invalid slots never write.

Timing:
- Latency: 1 cycle ID→EX.
- No combinational path from id_* data to ex_* outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_RegWrite=1, id_valid=1 → all ex_* outputs and stall_count are 0; pc_write=1.
- Pass-through: ADD-type bundle, id_rs=2, id_rt=3, id_rd=5, id_rdata1=0x10, id_ALUOperation=0001 → next cycle ex_RegWrite=1, ex_rd=5, ex_rdata1=0x10, ex_ALUOperation=0001, ex_valid=1.
- Load-use: LW to rt=4 in EX, dependent instruction in ID with id_rs=4, id_uses_rs=1 → pc_write=ifid_write=0 for one cycle, a bubble reaches EX, stall_count=1; the dependent instruction enters EX the following cycle.
- R0 and unused operand: LW to rt=0, id_rs=0 → no stall. LW to rt=6, id_rt=6 with id_uses_rt=0 → no stall.
- Flush priority: hazard and flush=1 in the same cycle → pc_write=1, EX bubble, stall_count unchanged.
- Saturation: CNT_W=2, four consecutive load-use pairs → stall_count sticks at 3.
